// File: rtl/lcd_frame_flush.sv
// rtl/lcd_frame_flush.sv - streams the RGB332 framebuffer to lcd_driver as a window header plus RGB565 byte pairs
// Every byte is one lcd_start pulse held until lcd_done; pixels are fetched with a one-cycle RAM latency.
module lcd_frame_flush #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 128,
  parameter int FB_AW  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [FB_AW-1:0] fb_raddr,
  input  logic [7:0]       fb_read_data,
  output logic [7:0]       lcd_data_in,
  output logic             lcd_data_dcx,
  output logic             lcd_start,
  input  logic             lcd_done
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_HDR      = 4'd1;
  localparam logic [3:0] S_HDR_WAIT = 4'd2;
  localparam logic [3:0] S_FETCH    = 4'd3;
  localparam logic [3:0] S_RDWAIT   = 4'd4;
  localparam logic [3:0] S_LATCH    = 4'd5;
  localparam logic [3:0] S_SEND_HI  = 4'd6;
  localparam logic [3:0] S_HI_WAIT  = 4'd7;
  localparam logic [3:0] S_SEND_LO  = 4'd8;
  localparam logic [3:0] S_LO_WAIT  = 4'd9;
  localparam logic [3:0] S_FIN      = 4'd10;

  localparam logic [3:0]       LAST_HDR = 4'd10;
  localparam logic [FB_AW-1:0] LAST_PIX = FB_AW'(WIDTH * HEIGHT - 1);

  logic [3:0]       state_q, state_d;
  logic [3:0]       hdr_idx_q, hdr_idx_d;
  logic [FB_AW-1:0] pix_q, pix_d;
  logic [7:0]       pix_reg_q, pix_reg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lcd_start_q, lcd_start_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             lcd_dcx_q, lcd_dcx_d;
  logic [FB_AW-1:0] fb_raddr_q, fb_raddr_d;

  logic [8:0] hdr_byte;
  logic [2:0] px_r, px_g;
  logic [1:0] px_b;
  logic [7:0] hi_byte, lo_byte;

  // Header entries are {dcx, byte}: CASET, RASET over the full panel, then RAMWR.
  always_comb begin
    hdr_byte = {1'b1, 8'h00};
    case (hdr_idx_q)
      4'd0:    hdr_byte = {1'b0, 8'h2A};
      4'd4:    hdr_byte = {1'b1, 8'(WIDTH - 1)};
      4'd5:    hdr_byte = {1'b0, 8'h2B};
      4'd9:    hdr_byte = {1'b1, 8'(HEIGHT - 1)};
      4'd10:   hdr_byte = {1'b0, 8'h2C};
      default: hdr_byte = {1'b1, 8'h00};
    endcase
  end

  assign px_r    = pix_reg_q[7:5];
  assign px_g    = pix_reg_q[4:2];
  assign px_b    = pix_reg_q[1:0];
  assign hi_byte = {px_r, px_r[2:1], px_g};
  assign lo_byte = {px_g, px_b, px_b, px_b[1]};

  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    pix_d       = pix_q;
    pix_reg_d   = pix_reg_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    lcd_start_d = 1'b0;
    lcd_data_d  = lcd_data_q;
    lcd_dcx_d   = lcd_dcx_q;
    fb_raddr_d  = fb_raddr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          hdr_idx_d = 4'd0;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        lcd_start_d             = 1'b1;
        {lcd_dcx_d, lcd_data_d} = hdr_byte;
        state_d                 = S_HDR_WAIT;
      end
      S_HDR_WAIT: begin
        if (lcd_done) begin
          if (hdr_idx_q == LAST_HDR) begin
            pix_d   = '0;
            state_d = S_FETCH;
          end else begin
            hdr_idx_d = hdr_idx_q + 4'd1;
            state_d   = S_HDR;
          end
        end
      end
      S_FETCH: begin
        fb_raddr_d = pix_q;
        state_d    = S_RDWAIT;
      end
      S_RDWAIT: state_d = S_LATCH;
      S_LATCH: begin
        pix_reg_d = fb_read_data;
        state_d   = S_SEND_HI;
      end
      S_SEND_HI: begin
        lcd_start_d = 1'b1;
        lcd_dcx_d   = 1'b1;
        lcd_data_d  = hi_byte;
        state_d     = S_HI_WAIT;
      end
      S_HI_WAIT: begin
        if (lcd_done) state_d = S_SEND_LO;
      end
      S_SEND_LO: begin
        lcd_start_d = 1'b1;
        lcd_dcx_d   = 1'b1;
        lcd_data_d  = lo_byte;
        state_d     = S_LO_WAIT;
      end
      S_LO_WAIT: begin
        if (lcd_done) begin
          if (pix_q == LAST_PIX) begin
            // done and busy change together while in FIN, so a start coinciding with done is dropped.
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_FIN;
          end else begin
            pix_d   = pix_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hdr_idx_q   <= '0;
      pix_q       <= '0;
      pix_reg_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lcd_start_q <= 1'b0;
      lcd_data_q  <= '0;
      lcd_dcx_q   <= 1'b0;
      fb_raddr_q  <= '0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      pix_q       <= pix_d;
      pix_reg_q   <= pix_reg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lcd_start_q <= lcd_start_d;
      lcd_data_q  <= lcd_data_d;
      lcd_dcx_q   <= lcd_dcx_d;
      fb_raddr_q  <= fb_raddr_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign fb_raddr     = fb_raddr_q;
  assign lcd_data_in  = lcd_data_q;
  assign lcd_data_dcx = lcd_dcx_q;
  assign lcd_start    = lcd_start_q;

endmodule

// File: tb/tb_lcd_frame_flush.sv
// tb/tb_lcd_frame_flush.sv - self-checking bench for lcd_frame_flush with a RAM model and an lcd_driver model
module tb_lcd_frame_flush;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 3;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, lcd_data_dcx, lcd_start;
  logic [AW-1:0] fb_raddr;
  logic [7:0]    fb_read_data = 8'h00;
  logic [7:0]    lcd_data_in;
  logic          lcd_done = 1'b0;

  lcd_frame_flush #(.WIDTH(W), .HEIGHT(H), .FB_AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .fb_raddr(fb_raddr), .fb_read_data(fb_read_data),
    .lcd_data_in(lcd_data_in), .lcd_data_dcx(lcd_data_dcx),
    .lcd_start(lcd_start), .lcd_done(lcd_done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [N];
  always @(posedge clk) fb_read_data <= mem[fb_raddr];

  int checks = 0;
  int errors = 0;

  // Driver model and protocol monitor
  bit            rand_delay = 0;
  int            fixed_delay = 3;
  bit            chk_stable = 1;
  bit            outstanding = 0;
  int            cnt = 0;
  logic [8:0]    held;
  logic [8:0]    cap_q[$];
  logic [AW-1:0] addr_q[$];
  logic [8:0]    exp_q[$];
  int            viol = 0, unstable = 0, done_cnt = 0, busy_err = 0;

  always @(negedge clk) begin
    lcd_done = 1'b0;
    if (lcd_start) begin
      if (outstanding) viol++;
      held = {lcd_data_dcx, lcd_data_in};
      cap_q.push_back(held);
      addr_q.push_back(fb_raddr);
      cnt = rand_delay ? int'($urandom_range(20, 1)) : fixed_delay;
      outstanding = 1;
      cnt--;
      if (cnt == 0) begin lcd_done = 1'b1; outstanding = 0; end
    end else if (outstanding) begin
      if (chk_stable && {lcd_data_dcx, lcd_data_in} !== held) unstable++;
      cnt--;
      if (cnt == 0) begin lcd_done = 1'b1; outstanding = 0; end
    end
    if (done) begin
      done_cnt++;
      if (busy) busy_err++;
    end
  end

  // Reference stream from the framebuffer contents using RGB565 arithmetic
  function automatic void build_expected();
    int r, g, b, rgb;
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h2A});
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'(W - 1)});
    exp_q.push_back({1'b0, 8'h2B});
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'(H - 1)});
    exp_q.push_back({1'b0, 8'h2C});
    for (int p = 0; p < N; p++) begin
      r = int'(mem[p]) / 32;
      g = (int'(mem[p]) / 4) % 8;
      b = int'(mem[p]) % 4;
      rgb = (r * 4 + r / 2) * 2048 + (g * 9) * 32 + (b * 10 + b / 2);
      exp_q.push_back({1'b1, 8'(rgb / 256)});
      exp_q.push_back({1'b1, 8'(rgb % 256)});
    end
  endfunction

  task automatic clear_logs();
    cap_q.delete(); addr_q.delete();
    viol = 0; unstable = 0; done_cnt = 0; busy_err = 0;
  endtask

  task automatic pulse_start();
    clear_logs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_start got %b want 1", busy);
    end
  endtask

  task automatic wait_done(string tag);
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    checks++;
    if (k >= 5000) begin
      errors++; $display("FAIL %s done_timeout got no done want done within 5000 cycles", tag);
    end
  endtask

  task automatic check_stream(string tag);
    int mism;
    bit addr_bad;
    build_expected();
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s byte_count got %0d want %0d", tag, cap_q.size(), exp_q.size());
    end
    mism = -1;
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      if (mism < 0 && cap_q[i] !== exp_q[i]) mism = i;
    checks++;
    if (mism >= 0) begin
      errors++; $display("FAIL %s byte_stream at %0d got %h want %h", tag, mism, cap_q[mism], exp_q[mism]);
    end
    addr_bad = 0;
    for (int p = 0; p < N; p++)
      if (11 + 2 * p >= addr_q.size() || addr_q[11 + 2 * p] !== AW'(p)) addr_bad = 1;
    checks++;
    if (addr_bad) begin
      errors++; $display("FAIL %s fb_raddr_seq got mismatch want 0..%0d", tag, N - 1);
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL %s done_count got %0d want 1", tag, done_cnt); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL %s start_overlap got %0d want 0", tag, viol); end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL %s hold_stable got %0d want 0", tag, unstable); end
    checks++;
    if (busy_err != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_with_done got %0d/%b want 0/0", tag, busy_err, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, lcd_start, lcd_data_dcx, lcd_data_in, fb_raddr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b start=%b dcx=%b data=%h addr=%h want all 0",
               busy, done, lcd_start, lcd_data_dcx, lcd_data_in, fb_raddr);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cap_q.size() != 0) begin
      errors++; $display("FAIL idle_quiet got busy=%b bytes=%0d want 0/0", busy, cap_q.size());
    end
  endtask

  task automatic test_fixed_frame();
    logic [7:0] pat [N];
    logic [7:0] lit [2*N];
    bit bad;
    pat = '{8'hFF, 8'hE0, 8'h1C, 8'h03, 8'h00, 8'hFF, 8'hE0, 8'h1C};
    lit = '{8'hFF, 8'hFF, 8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F,
            8'h00, 8'h00, 8'hFF, 8'hFF, 8'hF8, 8'h00, 8'h07, 8'hE0};
    for (int i = 0; i < N; i++) mem[i] = pat[i];
    rand_delay = 0; fixed_delay = 3;
    pulse_start();
    wait_done("fixed");
    @(negedge clk);
    check_stream("fixed");
    bad = 0;
    for (int i = 0; i < 2 * N; i++)
      if (11 + i >= cap_q.size() || cap_q[11 + i][7:0] !== lit[i]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL fixed_pixel_literals got mismatch want FF FF F8 00 07 E0 00 1F ..."); end
  endtask

  task automatic test_random_delay();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
      rand_delay = 1;
      pulse_start();
      wait_done("random");
      @(negedge clk);
      check_stream("random");
    end
    rand_delay = 0;
  endtask

  task automatic test_start_while_busy();
    int k;
    fixed_delay = 3;
    pulse_start();
    for (k = 0; k < 2000 && cap_q.size() < 17; k++) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start");
    @(negedge clk);
    check_stream("busy_start");
  endtask

  task automatic test_reset_mid_frame();
    int k, sz;
    fixed_delay = 6;
    pulse_start();
    for (k = 0; k < 2000 && cap_q.size() < 22; k++) @(negedge clk);
    chk_stable = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || lcd_start !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got busy=%b start=%b want 0/0", busy, lcd_start);
    end
    sz = cap_q.size();
    repeat (15) @(negedge clk);
    checks++;
    if (cap_q.size() != sz || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_quiet got bytes=%0d busy=%b want %0d/0", cap_q.size(), busy, sz);
    end
    chk_stable = 1;
    fixed_delay = 3;
    pulse_start();
    wait_done("restart");
    @(negedge clk);
    check_stream("restart");
  endtask

  task automatic test_done_collision();
    fixed_delay = 2;
    pulse_start();
    wait_done("collide");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_stream("collide");
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cap_q.size() != 11 + 2 * N) begin
      errors++; $display("FAIL start_with_done got busy=%b bytes=%0d want 0/%0d", busy, cap_q.size(), 11 + 2 * N);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    fixed_delay = 3;
    pulse_start();
    wait_done("b2b_first");
    @(negedge clk);
    check_stream("b2b_first");
    pulse_start();
    wait_done("b2b_second");
    @(negedge clk);
    check_stream("b2b_second");
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 8'h00;
    test_reset();
    test_fixed_frame();
    test_random_delay();
    test_start_while_busy();
    test_reset_mid_frame();
    test_done_collision();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
